sel_mux: RTL and testbench



---
 rtl/sel_mux.sv | 54 +++++
 tb/tb_sel_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sel_mux.sv
// Registered 2:1 selector for the RLE encoder output word: forwards either the
// literal data word or the zero-extended run count, one clock after sampling.
module sel_mux #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  count,
    input  logic              selector,
    output logic [DATA_W-1:0] muxout
);

    logic [DATA_W-1:0] count_ext;
    logic [DATA_W-1:0] muxout_d;
    logic [DATA_W-1:0] muxout_q;

    // A count wider than the output word cannot be represented without loss.
    generate
        if (CNT_W > DATA_W) begin : g_bad_widths
            $error("sel_mux: CNT_W (%0d) must not exceed DATA_W (%0d)", CNT_W, DATA_W);
        end
    endgenerate

    // The count is unsigned: pad with zeros, never with its top bit.
    generate
        if (CNT_W == DATA_W) begin : g_ext_none
            assign count_ext = count;
        end else if (CNT_W < DATA_W) begin : g_ext_zero
            assign count_ext = {{(DATA_W-CNT_W){1'b0}}, count};
        end else begin : g_ext_trunc
            assign count_ext = count[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        muxout_d = data;
        if (selector) begin
            muxout_d = count_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            muxout_q <= '0;
        end else begin
            muxout_q <= muxout_d;
        end
    end

    assign muxout = muxout_q;

endmodule

// File: tb/tb_sel_mux.sv
// Bench for sel_mux: directed vectors push their expected word into a queue
// at drive time; per-instance monitors pop and compare after each rising edge.
module tb_sel_mux;

    logic        clk;

    logic        rst32;
    logic [31:0] data32;
    logic [7:0]  count32;
    logic        sel32;
    logic [31:0] muxout32;

    logic        rst16;
    logic [15:0] data16;
    logic [15:0] count16;
    logic        sel16;
    logic [15:0] muxout16;

    logic [31:0] exp_q[$];
    logic [15:0] exp16_q[$];

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        sel;
        logic [31:0] data;
        logic [7:0]  count;
        logic [31:0] exp;
    } vec32_t;

    typedef struct {
        logic        rst;
        logic        sel;
        logic [15:0] data;
        logic [15:0] count;
        logic [15:0] exp;
    } vec16_t;

    sel_mux #(.DATA_W(32), .CNT_W(8)) u_dut32 (
        .clk      (clk),
        .rst      (rst32),
        .data     (data32),
        .count    (count32),
        .selector (sel32),
        .muxout   (muxout32)
    );

    sel_mux #(.DATA_W(16), .CNT_W(16)) u_dut16 (
        .clk      (clk),
        .rst      (rst16),
        .data     (data16),
        .count    (count16),
        .selector (sel16),
        .muxout   (muxout16)
    );

    // Clock and idle input values
    initial begin
        clk     = 1'b0;
        rst32   = 1'b1;
        data32  = '0;
        count32 = '0;
        sel32   = 1'b0;
        rst16   = 1'b1;
        data16  = '0;
        count16 = '0;
        sel16   = 1'b0;
        checks   = 0;
        failures = 0;
    end

    always #5 clk = ~clk;

    // Drivers: apply on the falling edge so the next rising edge samples it.
    task automatic step32(input vec32_t v);
        @(negedge clk);
        rst32   = v.rst;
        sel32   = v.sel;
        data32  = v.data;
        count32 = v.count;
        exp_q.push_back(v.exp);
    endtask

    task automatic step16(input vec16_t v);
        @(negedge clk);
        rst16   = v.rst;
        sel16   = v.sel;
        data16  = v.data;
        count16 = v.count;
        exp16_q.push_back(v.exp);
    endtask

    // Monitors
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (muxout32 !== e) begin
                    failures++;
                    $display("FAIL mux32 t=%0t got=%h expected=%h", $time, muxout32, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp16_q.size() > 0) begin
                e = exp16_q.pop_front();
                checks++;
                if (muxout16 !== e) begin
                    failures++;
                    $display("FAIL mux16 t=%0t got=%h expected=%h", $time, muxout16, e);
                end
            end
        end
    end

    vec32_t v32[$];
    vec16_t v16[$];

    initial begin
        // reset holds the output at zero despite an all-ones data word
        v32.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 8'h00, 32'h00000000});
        v32.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 8'h00, 32'h00000000});
        v32.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF});
        // data leg
        v32.push_back('{1'b0, 1'b0, 32'h00000000, 8'h0F, 32'h00000000});
        v32.push_back('{1'b0, 1'b0, 32'hA0A0A0A0, 8'h0F, 32'hA0A0A0A0});
        v32.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 8'h0F, 32'hFFFFFFFF});
        // count leg, data changes must not matter
        v32.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 8'h0F, 32'h0000000F});
        v32.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 8'h7F, 32'h0000007F});
        v32.push_back('{1'b0, 1'b1, 32'h00000000, 8'h7F, 32'h0000007F});
        // zero extension with count MSB set
        v32.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF, 32'h000000FF});
        // changing count on the unselected leg
        v32.push_back('{1'b0, 1'b0, 32'h12345678, 8'hAA, 32'h12345678});
        v32.push_back('{1'b0, 1'b0, 32'h12345678, 8'h55, 32'h12345678});
        // selector and selected input change together
        v32.push_back('{1'b0, 1'b1, 32'h12345678, 8'h3C, 32'h0000003C});
        v32.push_back('{1'b0, 1'b0, 32'h87654321, 8'h3C, 32'h87654321});
        // toggling with a one-cycle reset mid-pattern
        v32.push_back('{1'b0, 1'b0, 32'hA0A0A0A0, 8'h7F, 32'hA0A0A0A0});
        v32.push_back('{1'b0, 1'b1, 32'hA0A0A0A0, 8'h7F, 32'h0000007F});
        v32.push_back('{1'b0, 1'b0, 32'hA0A0A0A0, 8'h7F, 32'hA0A0A0A0});
        v32.push_back('{1'b1, 1'b1, 32'hA0A0A0A0, 8'h7F, 32'h00000000});
        v32.push_back('{1'b0, 1'b0, 32'hA0A0A0A0, 8'h7F, 32'hA0A0A0A0});
        v32.push_back('{1'b0, 1'b1, 32'hA0A0A0A0, 8'h7F, 32'h0000007F});
        v32.push_back('{1'b0, 1'b0, 32'hA0A0A0A0, 8'h7F, 32'hA0A0A0A0});

        // equal-width instance: no padding, MSB of count preserved
        v16.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h8001, 16'h0000});
        v16.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h8001, 16'h8001});
        v16.push_back('{1'b0, 1'b0, 16'h1234, 16'h8001, 16'h1234});
        v16.push_back('{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF});
        v16.push_back('{1'b0, 1'b1, 16'hAAAA, 16'h0001, 16'h0001});

        foreach (v32[i]) step32(v32[i]);
        foreach (v16[i]) step16(v16[i]);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || exp16_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d/%0d required=0/0", exp_q.size(), exp16_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
